scalar_mult_ctrl: RTL and testbench

- Sequencer for the extended-coordinate point adder/doubler. Computes Q = k·P with an MSB-first double-and-add loop.
- The point-op unit is instantiated by the parent; this block drives its start, mode and operand inputs and consumes its results and finish pulse.
- Input P is affine in standard form. Output Q is in Montgomery extended form (X,Y,Z,T), with R = 2^255 mod p = 19.
- Sits between the signature-top FSM and the point-op datapath.

---
 rtl/scalar_mult_ctrl_if.sv | 27 ++
 rtl/scalar_mult_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_scalar_mult_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/scalar_mult_ctrl_if.sv
// Handshake and operand bus between the scalar-multiply sequencer and the
// extended-coordinate point adder/doubler.
interface scalar_mult_ctrl_if;
  logic         pa_start;
  logic         pa_doubling;
  logic         pa_initial;
  logic [254:0] pa_x1, pa_y1, pa_z1, pa_t1;
  logic [254:0] pa_x2, pa_y2, pa_z2, pa_t2;
  logic [254:0] pa_x3, pa_y3, pa_z3, pa_t3;
  logic         pa_finished;

  modport master (
    output pa_start, pa_doubling, pa_initial,
    output pa_x1, pa_y1, pa_z1, pa_t1,
    output pa_x2, pa_y2, pa_z2, pa_t2,
    input  pa_x3, pa_y3, pa_z3, pa_t3,
    input  pa_finished
  );

  modport slave (
    input  pa_start, pa_doubling, pa_initial,
    input  pa_x1, pa_y1, pa_z1, pa_t1,
    input  pa_x2, pa_y2, pa_z2, pa_t2,
    output pa_x3, pa_y3, pa_z3, pa_t3,
    output pa_finished
  );
endinterface

// File: rtl/scalar_mult_ctrl.sv
// MSB-first double-and-add sequencer computing Q = k*P on an external point-op unit.
// Q is returned in Montgomery extended form (R = 19), one op outstanding at a time.
module scalar_mult_ctrl #(
  parameter int unsigned KW = 255,
  parameter int unsigned CW = 9
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [KW-1:0]       i_k,
  input  logic [254:0]        i_px,
  input  logic [254:0]        i_py,
  output logic                o_busy,
  output logic                o_done,
  output logic [254:0]        o_qx,
  output logic [254:0]        o_qy,
  output logic [254:0]        o_qz,
  output logic [254:0]        o_qt,
  output logic [CW-1:0]       o_op_count,
  scalar_mult_ctrl_if.master  pa_bus
);

  localparam int unsigned IW = (KW > 1) ? $clog2(KW) : 1;
  localparam logic [IW-1:0] IdxTop = IW'(KW - 1);
  localparam logic [254:0] RMont = 255'd19;

  typedef struct packed {
    logic [254:0] x;
    logic [254:0] y;
    logic [254:0] z;
    logic [254:0] t;
  } pt_t;

  localparam pt_t Neutral = '{x: '0, y: RMont, z: RMont, t: '0};

  typedef enum logic [3:0] {
    StIdle, StInitIssue, StInitWait, StScan, StDblIssue, StDblWait,
    StAddIssue, StAddWait, StNext, StDone, StDrain
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  pt_t           p_q, p_d, q_q, q_d, qo_q, res;
  logic [IW-1:0] idx_q, idx_d;
  logic          neutral_q, neutral_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, done_q, start_q, dbl_q, init_q;

  assign res = '{x: pa_bus.pa_x3, y: pa_bus.pa_y3, z: pa_bus.pa_z3, t: pa_bus.pa_t3};

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    p_d       = p_q;
    q_d       = q_q;
    idx_d     = idx_q;
    neutral_d = neutral_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          k_d       = i_k;
          p_d       = '{x: i_px, y: i_py, z: '0, t: '0};
          q_d       = Neutral;
          neutral_d = 1'b1;
          idx_d     = IdxTop;
          cnt_d     = '0;
          state_d   = StInitIssue;
        end
      end
      StInitIssue: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = i_abort ? StIdle : StInitWait;
      end
      StInitWait: begin
        if (i_abort) begin
          state_d = pa_bus.pa_finished ? StIdle : StDrain;
        end else if (pa_bus.pa_finished) begin
          p_d     = res;
          state_d = StScan;
        end
      end
      StScan: begin
        if (i_abort) begin
          state_d = StIdle;
        end else if (!neutral_q) begin
          state_d = StDblIssue;
        end else begin
          // Leading bits with Q still neutral cost no point ops
          if (k_q[idx_q]) begin
            q_d       = p_q;
            neutral_d = 1'b0;
          end
          if (idx_q == '0) state_d = StDone;
          else idx_d = idx_q - 1'b1;
        end
      end
      StDblIssue: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = i_abort ? StIdle : StDblWait;
      end
      StDblWait: begin
        if (i_abort) begin
          state_d = pa_bus.pa_finished ? StIdle : StDrain;
        end else if (pa_bus.pa_finished) begin
          q_d     = res;
          state_d = k_q[idx_q] ? StAddIssue : StNext;
        end
      end
      StAddIssue: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = i_abort ? StIdle : StAddWait;
      end
      StAddWait: begin
        if (i_abort) begin
          state_d = pa_bus.pa_finished ? StIdle : StDrain;
        end else if (pa_bus.pa_finished) begin
          q_d     = res;
          state_d = StNext;
        end
      end
      StNext: begin
        if (i_abort) begin
          state_d = StIdle;
        end else if (idx_q == '0) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = StDblIssue;
        end
      end
      StDone:  state_d = StIdle;
      StDrain: if (pa_bus.pa_finished) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      k_q       <= '0;
      p_q       <= '0;
      q_q       <= Neutral;
      qo_q      <= Neutral;
      idx_q     <= IdxTop;
      neutral_q <= 1'b1;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      dbl_q     <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      p_q       <= p_d;
      q_q       <= q_d;
      idx_q     <= idx_d;
      neutral_q <= neutral_d;
      cnt_q     <= cnt_d;
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_d == StDone);
      start_q   <= (state_d inside {StInitIssue, StDblIssue, StAddIssue});
      dbl_q     <= (state_d == StDblIssue);
      init_q    <= (state_d == StInitIssue);
      if (state_d == StDone) qo_q <= q_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_op_count = cnt_q;
  assign o_qx       = qo_q.x;
  assign o_qy       = qo_q.y;
  assign o_qz       = qo_q.z;
  assign o_qt       = qo_q.t;

  // The init op converts affine P, which rides on the operand-1 lanes
  assign pa_bus.pa_start    = start_q;
  assign pa_bus.pa_doubling = dbl_q;
  assign pa_bus.pa_initial  = init_q;
  assign pa_bus.pa_x1       = init_q ? p_q.x : q_q.x;
  assign pa_bus.pa_y1       = init_q ? p_q.y : q_q.y;
  assign pa_bus.pa_z1       = q_q.z;
  assign pa_bus.pa_t1       = q_q.t;
  assign pa_bus.pa_x2       = p_q.x;
  assign pa_bus.pa_y2       = p_q.y;
  assign pa_bus.pa_z2       = p_q.z;
  assign pa_bus.pa_t2       = p_q.t;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Directed bench for scalar_mult_ctrl with a linear stand-in for the point-op unit,
// so that k*P has a closed form: x = k*Ix, y = 19 + k*(Iy-19), z = 19, t = k*It.
module tb_scalar_mult_ctrl;
  localparam int unsigned KW = 255;
  localparam int unsigned CW = 9;
  localparam logic [254:0] R  = 255'd19;
  localparam logic [254:0] BX =
    255'h216936D3CD6E53FEC0A4E231FDD6DC5C692CC7609525A7B2C9562D608F25D51A;
  localparam logic [254:0] BY =
    255'h6666666666666666666666666666666666666666666666666666666666666658;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [KW-1:0] k;
  logic [254:0] px, py, qx, qy, qz, qt;
  logic busy, done;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  scalar_mult_ctrl_if bus ();

  scalar_mult_ctrl #(.KW(KW), .CW(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_k(k),
    .i_px(px), .i_py(py), .o_busy(busy), .o_done(done),
    .o_qx(qx), .o_qy(qy), .o_qz(qz), .o_qt(qt), .o_op_count(op_count),
    .pa_bus(bus)
  );

  // Point-op stand-in: fixed latency, result valid with the finish pulse
  int unsigned lat = 3;
  int unsigned mcnt;
  logic fin_model, fin_spur;
  logic [254:0] rx, ry, rz, rt;
  assign bus.pa_finished = fin_model | fin_spur;
  assign bus.pa_x3 = rx;
  assign bus.pa_y3 = ry;
  assign bus.pa_z3 = rz;
  assign bus.pa_t3 = rt;

  always @(posedge clk) begin
    logic [254:0] tx, ty, tz, tt;
    if (rst) begin
      mcnt <= 0;
      fin_model <= 1'b0;
    end else begin
      fin_model <= 1'b0;
      if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) fin_model <= 1'b1;
      end else if (bus.pa_start) begin
        if (bus.pa_initial) begin
          tx = bus.pa_x1 * R; ty = bus.pa_y1 * R; tz = R; tt = tx ^ ty;
        end else if (bus.pa_doubling) begin
          tx = bus.pa_x1 + bus.pa_x1; ty = bus.pa_y1 + bus.pa_y1 - R;
          tz = bus.pa_z1; tt = bus.pa_t1 + bus.pa_t1;
        end else begin
          tx = bus.pa_x1 + bus.pa_x2; ty = bus.pa_y1 + bus.pa_y2 - R;
          tz = bus.pa_z1; tt = bus.pa_t1 + bus.pa_t2;
        end
        rx <= tx; ry <= ty; rz <= tz; rt <= tt;
        mcnt <= lat;
      end
    end
  end

  int n_init = 0, n_dbl = 0, n_add = 0, n_done = 0, n_fin = 0, n_overlap = 0, n_gap = 0;
  logic job_on = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pa_start) begin
        if (mcnt != 0) n_overlap++;
        if (bus.pa_initial) n_init++;
        else if (bus.pa_doubling) n_dbl++;
        else n_add++;
      end
      if (bus.pa_finished) n_fin++;
      if (done) n_done++;
      if (job_on && !busy) n_gap++;
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  int i0, d0, a0, dn0, g0, f0;
  logic [254:0] ix, iy, it, ex, ey, ez, et;

  task automatic check(input string tag, input logic [254:0] obs, input logic [254:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [254:0] kmul(input logic [254:0] kv, input logic [254:0] v);
    logic [254:0] r;
    r = kv * v;
    return r;
  endfunction

  task automatic expect_pt(input logic [KW-1:0] kv);
    ex = kmul(kv, ix);
    ey = R + kmul(kv, iy - R);
    ez = R;
    et = kmul(kv, it);
  endtask

  task automatic snap();
    i0 = n_init; d0 = n_dbl; a0 = n_add; dn0 = n_done; g0 = n_gap; f0 = n_fin;
  endtask

  task automatic launch(input logic [KW-1:0] kv);
    k = kv; px = BX; py = BY; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    job_on = 1'b1;
  endtask

  // Runs a full job; optionally pulses i_start and a stray pa_finished mid-scan
  task automatic run_job(input string nm, input logic [KW-1:0] kv, input bit disturb,
                         input int ops, input int dbls, input int adds);
    snap();
    launch(kv);
    for (int c = 0; c < 6000; c++) begin
      if (done) break;
      if (disturb && c == 50) begin start = 1'b1; k = '1; fin_spur = 1'b1; end
      if (disturb && c == 51) begin start = 1'b0; k = kv; fin_spur = 1'b0; end
      @(negedge clk);
    end
    check({nm, "_done_seen"}, done, 1'b1);
    job_on = 1'b0;
    @(negedge clk);
    expect_pt(kv);
    check({nm, "_done_one_cycle"}, done, 1'b0);
    check({nm, "_idle_after"}, busy, 1'b0);
    check({nm, "_qx"}, qx, ex);
    check({nm, "_qy"}, qy, ey);
    check({nm, "_qz"}, qz, ez);
    check({nm, "_qt"}, qt, et);
    check({nm, "_op_count"}, op_count, 255'(ops));
    check({nm, "_init_ops"}, 255'(n_init - i0), 255'd1);
    check({nm, "_dbl_ops"}, 255'(n_dbl - d0), 255'(dbls));
    check({nm, "_add_ops"}, 255'(n_add - a0), 255'(adds));
    check({nm, "_done_pulses"}, 255'(n_done - dn0), 255'd1);
    check({nm, "_busy_gap"}, 255'(n_gap - g0), 255'd0);
  endtask

  initial begin
    logic [KW-1:0] kv;
    logic [254:0] hx, hy, hz, ht;
    ix = BX * R;
    iy = BY * R;
    it = ix ^ iy;
    rst = 1'b1; start = 1'b0; abort = 1'b0; fin_spur = 1'b0;
    k = '0; px = '0; py = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_op_count", op_count, '0);
    check("rst_pa_start", bus.pa_start, 1'b0);
    check("rst_pa_doubling", bus.pa_doubling, 1'b0);
    check("rst_pa_initial", bus.pa_initial, 1'b0);
    check("rst_q_x", bus.pa_x1, '0);
    check("rst_q_y", bus.pa_y1, R);
    check("rst_q_z", bus.pa_z1, R);
    check("rst_q_t", bus.pa_t1, '0);
    check("rst_p_x", bus.pa_x2, '0);

    run_job("k0", '0, 1'b0, 1, 0, 0);
    kv = '0; kv[0] = 1'b1;
    run_job("k1", kv, 1'b0, 1, 0, 0);
    kv = '0; kv[1:0] = 2'b11;
    run_job("k3", kv, 1'b1, 3, 1, 1);
    kv = '0; kv[254] = 1'b1; kv[0] = 1'b1;
    run_job("kbig", kv, 1'b0, 256, 254, 1);
    hx = ex; hy = ey; hz = ez; ht = et;

    // Abort while a doubling is in flight on a slow point-op
    lat = 40;
    snap();
    kv = '0; kv[254] = 1'b1;
    launch(kv);
    for (int c = 0; c < 2000; c++) begin
      if (bus.pa_start && bus.pa_doubling) break;
      @(negedge clk);
    end
    check("ab_dbl_issued", bus.pa_start & bus.pa_doubling, 1'b1);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    job_on = 1'b0;
    repeat (10) @(negedge clk);
    check("ab_drain_busy", busy, 1'b1);
    for (int c = 0; c < 200; c++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("ab_idle", busy, 1'b0);
    check("ab_finish_seen", 255'(n_fin - f0), 255'd2);
    check("ab_no_done", 255'(n_done - dn0), 255'd0);
    check("ab_no_more_ops", 255'(n_dbl - d0), 255'd1);
    check("ab_op_count", op_count, 255'd2);
    check("ab_qx_kept", qx, hx);
    check("ab_qy_kept", qy, hy);
    check("ab_qz_kept", qz, hz);
    check("ab_qt_kept", qt, ht);

    lat = 3;
    @(negedge clk);
    kv = '0; kv[1] = 1'b1;
    run_job("k2", kv, 1'b0, 2, 1, 0);

    check("no_overlap", 255'(n_overlap), 255'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
